// File: rtl/rv32_cpu_cp_bitmanip_ser_if.sv
// Start/operand/result bundle between the RV32 ALU co-processor slot and the
// serial bit-manipulation unit.
interface rv32_cpu_cp_bitmanip_ser_if #(
  parameter int XLEN = 32
);
  logic            i_start;
  logic            i_cpu_trap;
  logic [2:0]      i_op;
  logic [XLEN-1:0] i_rs1;
  logic [4:0]      i_shamt;
  logic [XLEN-1:0] o_res;
  logic            o_valid;

  // ALU side: issues starts and operands, collects the strobed result.
  modport master (
    output i_start, i_cpu_trap, i_op, i_rs1, i_shamt,
    input  o_res, o_valid
  );

  // Co-processor side.
  modport slave (
    input  i_start, i_cpu_trap, i_op, i_rs1, i_shamt,
    output o_res, o_valid
  );
endinterface

// File: rtl/rv32_cpu_cp_bitmanip_ser.sv
// Serial CLZ/CTZ/CPOP/ROL/ROR co-processor: one bit step per clock, result
// strobed for one cycle from the DONE state and zero otherwise.
module rv32_cpu_cp_bitmanip_ser #(
  parameter int XLEN = 32
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  rv32_cpu_cp_bitmanip_ser_if.slave    bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_e;

  typedef enum logic [2:0] {
    OP_CLZ  = 3'b000,
    OP_CTZ  = 3'b001,
    OP_CPOP = 3'b010,
    OP_ROL  = 3'b011,
    OP_ROR  = 3'b100
  } op_e;

  state_e          state, state_d;
  logic [XLEN-1:0] sreg, sreg_d;
  logic [2:0]      op, op_d;
  logic [5:0]      cnt, cnt_d;
  logic [4:0]      rem, rem_d;
  logic [4:0]      step, step_d;
  logic [XLEN-1:0] result;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values computed by the comb block below.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= ST_IDLE;
      sreg  <= '0;
      op    <= '0;
      cnt   <= '0;
      rem   <= '0;
      step  <= '0;
    end else begin
      state <= state_d;
      sreg  <= sreg_d;
      op    <= op_d;
      cnt   <= cnt_d;
      rem   <= rem_d;
      step  <= step_d;
    end
  end

  // NOTE: every comb output holds its current value by default before any
  // branch, so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state;
    sreg_d  = sreg;
    op_d    = op;
    cnt_d   = cnt;
    rem_d   = rem;
    step_d  = step;

    unique case (state)
      ST_IDLE: begin
        if (bus.i_start) begin
          sreg_d  = bus.i_rs1;
          op_d    = bus.i_op;
          cnt_d   = '0;
          rem_d   = bus.i_shamt;
          step_d  = '0;
          state_d = ST_BUSY;
        end
      end

      ST_BUSY: begin
        if (bus.i_cpu_trap) begin
          state_d = ST_IDLE;
        end else begin
          case (op)
            OP_CLZ: begin
              if (sreg[XLEN-1]) begin
                state_d = ST_DONE;
              end else begin
                sreg_d = sreg << 1;
                cnt_d  = cnt + 6'd1;
                if (cnt == 6'd31) state_d = ST_DONE;
              end
            end

            OP_CTZ: begin
              if (sreg[0]) begin
                state_d = ST_DONE;
              end else begin
                sreg_d = sreg >> 1;
                cnt_d  = cnt + 6'd1;
                if (cnt == 6'd31) state_d = ST_DONE;
              end
            end

            OP_CPOP: begin
              // Fixed 32 steps: the 5-bit step counter terminates on its wrap.
              cnt_d  = cnt + {5'd0, sreg[0]};
              sreg_d = sreg >> 1;
              step_d = step + 5'd1;
              if (step == 5'd31) state_d = ST_DONE;
            end

            OP_ROL: begin
              if (rem == 5'd0) begin
                state_d = ST_DONE;
              end else begin
                sreg_d = {sreg[XLEN-2:0], sreg[XLEN-1]};
                rem_d  = rem - 5'd1;
                if (rem == 5'd1) state_d = ST_DONE;
              end
            end

            OP_ROR: begin
              if (rem == 5'd0) begin
                state_d = ST_DONE;
              end else begin
                sreg_d = {sreg[0], sreg[XLEN-1:1]};
                rem_d  = rem - 5'd1;
                if (rem == 5'd1) state_d = ST_DONE;
              end
            end

            default: state_d = ST_DONE;
          endcase
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  // Result is decoded from registered state only and zero outside DONE, so
  // it can be OR-combined with the other co-processors' results.
  always_comb begin
    result = '0;
    if (state == ST_DONE) begin
      case (op)
        OP_CLZ, OP_CTZ, OP_CPOP: result = XLEN'(cnt);
        OP_ROL, OP_ROR:          result = sreg;
        default:                 result = '0;
      endcase
    end
  end

  assign bus.o_res   = result;
  assign bus.o_valid = (state == ST_DONE);

endmodule

// File: tb/tb_rv32_cpu_cp_bitmanip_ser.sv
// Randomized and directed bench for the serial bit-manipulation co-processor,
// checked every cycle against an arithmetic reference model.
module tb_rv32_cpu_cp_bitmanip_ser;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rv32_cpu_cp_bitmanip_ser_if #(.XLEN(32)) bus ();

  rv32_cpu_cp_bitmanip_ser #(.XLEN(32)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  int vectors = 0;
  int errors  = 0;

  // Model state: one outstanding operation at most.
  logic        m_busy       = 1'b0;
  int          m_valid_edge = 0;
  int          m_free_edge  = 0;
  int          m_s          = 0;
  logic [31:0] m_res        = '0;

  int          strobes  = 0;
  logic [31:0] cap_res  = '0;
  int          cap_edge = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %h, expected %h", name, edge_n, act, exp);
    end
  endtask

  function automatic int lead_zeros(input logic [31:0] a);
    int n = 0;
    while (n < 32 && !a[31-n]) n++;
    return n;
  endfunction

  function automatic int trail_zeros(input logic [31:0] a);
    int n = 0;
    while (n < 32 && !a[n]) n++;
    return n;
  endfunction

  function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a,
                                          input logic [4:0] sh);
    case (op)
      3'd0: return 32'(lead_zeros(a));
      3'd1: return 32'(trail_zeros(a));
      3'd2: return 32'($countones(a));
      3'd3: return (sh == 0) ? a : ((a << sh) | (a >> (32 - int'(sh))));
      3'd4: return (sh == 0) ? a : ((a >> sh) | (a << (32 - int'(sh))));
      default: return 32'd0;
    endcase
  endfunction

  function automatic int ref_steps(input logic [2:0] op, input logic [31:0] a,
                                   input logic [4:0] sh);
    case (op)
      3'd0: return (lead_zeros(a) + 1 > 32) ? 32 : lead_zeros(a) + 1;
      3'd1: return (trail_zeros(a) + 1 > 32) ? 32 : trail_zeros(a) + 1;
      3'd2: return 32;
      3'd3, 3'd4: return (sh == 0) ? 1 : int'(sh);
      default: return 1;
    endcase
  endfunction

  // Per-cycle compare: o_valid must be high exactly in the cycle before the
  // model's valid-sample edge, and o_res must be zero whenever it is low.
  always @(negedge clk) begin
    logic exp_v;
    exp_v = m_busy && (m_valid_edge == edge_n + 1);
    check("o_valid", {31'd0, bus.o_valid}, {31'd0, exp_v});
    check("o_res", bus.o_res, exp_v ? m_res : 32'd0);
    if (bus.o_valid) begin
      strobes++;
      cap_res  = bus.o_res;
      cap_edge = edge_n + 1;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Drives a one-cycle start; l returns the edge that samples it.
  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [4:0] sh,
                          output int l);
    bus.i_op    = op;
    bus.i_rs1   = a;
    bus.i_shamt = sh;
    bus.i_start = 1'b1;
    l = edge_n + 1;
    if (l >= m_free_edge) begin
      m_s          = ref_steps(op, a, sh);
      m_res        = ref_res(op, a, sh);
      m_valid_edge = l + m_s + 1;
      m_free_edge  = m_valid_edge + 1;
      m_busy       = 1'b1;
    end
    tick();
    bus.i_start = 1'b0;
    bus.i_op    = 3'($urandom);
    bus.i_rs1   = $urandom;
    bus.i_shamt = 5'($urandom);
  endtask

  task automatic trap_pulse();
    int t;
    bus.i_cpu_trap = 1'b1;
    t = edge_n + 1;
    if (m_busy && t >= m_valid_edge - m_s && t <= m_valid_edge - 1) begin
      m_busy      = 1'b0;
      m_free_edge = t + 1;
    end
    tick();
    bus.i_cpu_trap = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 50 && edge_n + 1 < m_free_edge; i++) tick();
    if (edge_n + 1 < m_free_edge) check("idle_timeout", 32'(edge_n), 32'(m_free_edge));
  endtask

  task automatic directed(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [4:0] sh, input logic [31:0] exp_res, input int exp_lat);
    int l;
    int s0;
    s0 = strobes;
    start_op(op, a, sh, l);
    wait_idle();
    check({name, "_res"}, cap_res, exp_res);
    check({name, "_lat"}, 32'(cap_edge - l), 32'(exp_lat));
    check({name, "_strobes"}, 32'(strobes - s0), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_busy      = 1'b0;
    m_free_edge = 0;
    #1;
    check("rst_valid", {31'd0, bus.o_valid}, 32'd0);
    check("rst_res", bus.o_res, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    int l;
    int s0;
    rst            = 1'b1;
    bus.i_start    = 1'b0;
    bus.i_cpu_trap = 1'b0;
    bus.i_op       = '0;
    bus.i_rs1      = '0;
    bus.i_shamt    = '0;
    tick();
    do_reset();

    // Hand-computed expectations.
    directed("clz_bit16",  3'd0, 32'h0001_0000, 5'd0, 32'd15, 17);
    directed("clz_msb",    3'd0, 32'h8000_0000, 5'd0, 32'd0, 2);
    directed("ctz_zero",   3'd1, 32'h0000_0000, 5'd0, 32'd32, 33);
    directed("ctz_bit3",   3'd1, 32'h0000_0008, 5'd0, 32'd3, 5);
    directed("cpop_f0",    3'd2, 32'hF0F0_F0F0, 5'd0, 32'd16, 33);
    directed("cpop_ones",  3'd2, 32'hFFFF_FFFF, 5'd0, 32'd32, 33);
    directed("ror4",       3'd4, 32'h0000_0001, 5'd4, 32'h1000_0000, 5);
    directed("rol1",       3'd3, 32'h8000_0001, 5'd1, 32'h0000_0003, 2);
    directed("rol0",       3'd3, 32'h1234_5678, 5'd0, 32'h1234_5678, 2);
    directed("reserved",   3'd6, 32'hDEAD_BEEF, 5'd7, 32'd0, 2);

    // Trap mid-CPOP: no strobe through edge 40, then a clean CLZ.
    s0 = strobes;
    start_op(3'd2, 32'hF0F0_F0F0, 5'd0, l);
    while (edge_n < l + 9) tick();
    trap_pulse();
    while (edge_n < l + 40) tick();
    check("trap_strobes", 32'(strobes - s0), 32'd0);
    directed("clz_after_trap", 3'd0, 32'h0000_00FF, 5'd0, 32'd24, 26);

    // Second start while busy is ignored.
    s0 = strobes;
    start_op(3'd1, 32'h0000_0008, 5'd0, l);
    tick();
    begin
      int l2;
      start_op(3'd0, 32'h0000_0001, 5'd0, l2);
    end
    wait_idle();
    check("busy_start_res", cap_res, 32'd3);
    check("busy_start_lat", 32'(cap_edge - l), 32'd5);
    check("busy_start_strobes", 32'(strobes - s0), 32'd1);

    // Reset mid-CTZ discards the operation.
    s0 = strobes;
    start_op(3'd1, 32'h0000_0000, 5'd0, l);
    repeat (4) tick();
    do_reset();
    while (edge_n < l + 40) tick();
    check("rst_busy_strobes", 32'(strobes - s0), 32'd0);

    // Reset during the DONE cycle clears the strobe asynchronously.
    start_op(3'd4, 32'h0000_0001, 5'd4, l);
    repeat (4) tick();
    check("pre_rst_valid", {31'd0, bus.o_valid}, 32'd1);
    s0 = strobes;
    do_reset();
    while (edge_n < l + 40) tick();
    check("rst_done_strobes", 32'(strobes - s0), 32'd0);

    // Randomized operations with occasional traps and ignored starts.
    for (int n = 0; n < 150; n++) begin
      logic [2:0]  op;
      logic [31:0] a;
      logic [4:0]  sh;
      int          act;
      op = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: a = $urandom;
        1: a = $urandom >> $urandom_range(0, 31);
        2: a = $urandom << $urandom_range(0, 31);
        default: a = ($urandom_range(0, 3) == 0) ? 32'd0 : (32'd1 << $urandom_range(0, 31));
      endcase
      sh = 5'($urandom);
      start_op(op, a, sh, l);
      act = $urandom_range(0, 7);
      if (act == 0) begin
        repeat ($urandom_range(0, m_s)) tick();
        trap_pulse();
      end else if (act == 1 && m_s >= 2) begin
        int l2;
        repeat ($urandom_range(0, m_s - 2)) tick();
        start_op(3'($urandom), $urandom, 5'($urandom), l2);
      end
      wait_idle();
      repeat ($urandom_range(0, 2)) tick();
    end

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
